count_sched: RTL and testbench

- Sequencer for the synchronous mod-N counter datapath.
- Owns a programmable prescaler and runs a bounded acquisition burst of N timing windows on request.
- Emits one `tick` per window and a `done` pulse at the end of the burst.
- Sits between the slow-control register interface (cfg/start/abort) and the downstream logic that consumes `tick` and `win_idx`.

---
 rtl/count_pkg.sv | 16 +
 rtl/count_mod.sv | 36 +++
 rtl/count_sched.sv | 115 +++++++++++
 tb/tb_count_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared types and defaults for the count_sched burst sequencer.
package count_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned CNT_W_DFLT     = 10;
  localparam int unsigned NWIN_W_DFLT    = 8;
  localparam int unsigned DEFAULT_PERIOD = 1000;
  localparam int unsigned DEFAULT_NWIN   = 1;
  localparam int unsigned MIN_PERIOD     = 2;

endpackage

// File: rtl/count_mod.sv
// Mod-period counter with enable and sync clear; period is a runtime input.
module count_mod #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] period,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;

  assign wrap  = (count_q == period - W'(1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/count_sched.sv
// Burst sequencer: runs nwin prescaled windows on start, emitting tick per window and done at end.
module count_sched
  import count_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DFLT,
  parameter int unsigned DEFAULT_PERIOD = count_pkg::DEFAULT_PERIOD,
  parameter int unsigned NWIN_W         = NWIN_W_DFLT,
  parameter int unsigned DEFAULT_NWIN   = count_pkg::DEFAULT_NWIN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [NWIN_W-1:0] cfg_nwin,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              tick,
  output logic [NWIN_W-1:0] win_idx,
  output logic [CNT_W-1:0]  count,
  output logic              done,
  output logic              aborted,
  output logic              cfg_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [NWIN_W-1:0] nwin_q, nwin_d;
  logic [NWIN_W-1:0] win_q, win_d;
  logic              aborted_q, cfg_err_q, cfg_err_d;
  logic              wrap, start_fire, abort_fire, last_win, cfg_ok;

  assign start_fire = (state_q == StIdle) && start && !abort;
  assign abort_fire = (state_q == StRun) && abort;
  assign tick       = (state_q == StRun) && wrap && !abort;
  assign last_win   = (win_q == nwin_q - NWIN_W'(1));
  assign cfg_ok     = (cfg_period >= CNT_W'(MIN_PERIOD)) && (cfg_nwin != '0);

  // Clearing on abort as well keeps count at 0 whenever the FSM is outside RUN.
  count_mod #(
    .W(CNT_W)
  ) u_count_mod (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == StRun),
    .clr   (start_fire || abort_fire),
    .period(period_q),
    .count (count),
    .wrap  (wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_fire) state_d = StRun;
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (tick && last_win) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    win_d = win_q;
    if (state_d != StRun) begin
      win_d = '0;
    end else if (tick && !last_win) begin
      win_d = win_q + NWIN_W'(1);
    end
  end

  always_comb begin
    period_d  = period_q;
    nwin_d    = nwin_q;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      if ((state_q == StIdle) && cfg_ok) begin
        period_d = cfg_period;
        nwin_d   = cfg_nwin;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      period_q  <= CNT_W'(DEFAULT_PERIOD);
      nwin_q    <= NWIN_W'(DEFAULT_NWIN);
      win_q     <= '0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      nwin_q    <= nwin_d;
      win_q     <= win_d;
      aborted_q <= abort_fire;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign win_idx = win_q;
  assign aborted = aborted_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_count_sched.sv
// Randomized and directed checks of count_sched against a burst-timing reference model.
module tb_count_sched;

  localparam int CW = 10;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset, cfg_we, start, abort;
  logic [CW-1:0] cfg_period;
  logic [NW-1:0] cfg_nwin;
  logic          busy, tick, done, aborted, cfg_err;
  logic [NW-1:0] win_idx;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  // Reference model: a burst is "elapsed cycles since start"; outputs follow by arithmetic.
  int  m_period, m_nwin, m_t;
  bit  m_run, m_done, m_ab, m_err;
  logic [22:0] exp_vec;

  count_sched #(
    .CNT_W         (CW),
    .DEFAULT_PERIOD(1000),
    .NWIN_W        (NW),
    .DEFAULT_NWIN  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_period(cfg_period),
    .cfg_nwin  (cfg_nwin),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .tick      (tick),
    .win_idx   (win_idx),
    .count     (count),
    .done      (done),
    .aborted   (aborted),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] obs();
    return {busy, tick, done, aborted, cfg_err, win_idx, count};
  endfunction

  function automatic logic [22:0] model_out(bit a);
    int c;
    int w;
    bit t;
    c = m_run ? m_t % m_period : 0;
    w = m_run ? m_t / m_period : 0;
    t = m_run && (c == m_period - 1) && !a;
    return {m_run, t, m_done, m_ab, m_err, NW'(w), CW'(c)};
  endfunction

  task automatic model_reset();
    m_period = 1000;
    m_nwin   = 1;
    m_t      = 0;
    m_run    = 1'b0;
    m_done   = 1'b0;
    m_ab     = 1'b0;
    m_err    = 1'b0;
  endtask

  // Drive one cycle's inputs and compute the expected outputs mid-cycle.
  task automatic apply(input bit s, input bit a, input bit we, input int p, input int n);
    start      = s;
    abort      = a;
    cfg_we     = we;
    cfg_period = CW'(p);
    cfg_nwin   = NW'(n);
    @(negedge clk);
    exp_vec = model_out(a);
  endtask

  // Take the clock edge and advance the model by the same edge.
  task automatic advance();
    bit idle, nd, na, ne;
    int np, nn;
    @(posedge clk);
    idle = !m_run && !m_done;
    nd   = 1'b0;
    na   = 1'b0;
    ne   = 1'b0;
    np   = int'(cfg_period);
    nn   = int'(cfg_nwin);
    if (cfg_we) begin
      if (idle && np >= 2 && nn >= 1) begin
        m_period = np;
        m_nwin   = nn;
      end else begin
        ne = 1'b1;
      end
    end
    if (m_run) begin
      if (abort) begin
        m_run = 1'b0;
        na    = 1'b1;
      end else if (m_t + 1 == m_nwin * m_period) begin
        m_run = 1'b0;
        nd    = 1'b1;
      end else begin
        m_t++;
      end
    end else if (!m_done && start && !abort) begin
      m_run = 1'b1;
      m_t   = 0;
    end
    m_done = nd;
    m_ab   = na;
    m_err  = ne;
    #1;
  endtask

  task automatic test_reset();
    int ticks, done_at;
    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    cfg_period = '0; cfg_nwin = '0;
    model_reset();
    #2;
    total++;
    if (obs() !== 23'd0) begin
      bad++; $display("FAIL reset_init got=%h want=%h", obs(), 23'd0);
    end
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 38; i++) begin
      apply(i == 0, 1'b0, 1'b0, 0, 0);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL reset_run c%0d got=%h want=%h", i, obs(), exp_vec);
      end
      advance();
    end
    reset = 1'b1;
    #1;
    total++;
    if (obs() !== 23'd0) begin
      bad++; $display("FAIL reset_mid got=%h want=%h", obs(), 23'd0);
    end
    model_reset();
    @(posedge clk); #1; reset = 1'b0;
    ticks = 0; done_at = -1;
    for (int i = 0; i < 1004; i++) begin
      apply(i == 0, 1'b0, 1'b0, 0, 0);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL reset_dflt c%0d got=%h want=%h", i, obs(), exp_vec);
      end
      if (tick) ticks++;
      if (done && done_at < 0) done_at = i;
      advance();
    end
    total++;
    if (ticks !== 1 || done_at !== 1001) begin
      bad++; $display("FAIL reset_defaults ticks=%0d done_at=%0d want 1 and 1001", ticks, done_at);
    end
  endtask

  task automatic test_nominal();
    logic [31:0] tick_mask, busy_mask;
    int done_at;
    tick_mask = '0; busy_mask = '0; done_at = -1;
    for (int i = 0; i < 18; i++) begin
      apply(i == 1, 1'b0, i == 0, 4, 3);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL nominal c%0d got=%h want=%h", i, obs(), exp_vec);
      end
      tick_mask[i] = tick;
      busy_mask[i] = busy;
      if (done && done_at < 0) done_at = i;
      advance();
    end
    total++;
    if (tick_mask !== 32'h0000_2220 || busy_mask !== 32'h0000_3ffc || done_at !== 14) begin
      bad++;
      $display("FAIL nominal_timing ticks=%h busy=%h done_at=%0d want 2220 3ffc 14",
               tick_mask, busy_mask, done_at);
    end
  endtask

  task automatic test_abort();
    int ab_cnt, done_cnt;
    logic t_at_abort;
    logic [10:0] after;
    ab_cnt = 0; done_cnt = 0; t_at_abort = 1'bx; after = 'x;
    for (int i = 0; i < 20; i++) begin
      apply(i == 1, i == 11, i == 0, 5, 4);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL abort c%0d got=%h want=%h", i, obs(), exp_vec);
      end
      if (i == 11) t_at_abort = tick;
      if (i == 12) after = {busy, aborted, win_idx, count == '0};
      if (aborted) ab_cnt++;
      if (done) done_cnt++;
      advance();
    end
    total++;
    if (t_at_abort !== 1'b0 || after !== {1'b0, 1'b1, 8'd0, 1'b1} || ab_cnt !== 1 ||
        done_cnt !== 0) begin
      bad++;
      $display("FAIL abort_prio tick=%b after=%b aborted=%0d done=%0d want 0 01000000001 1 0",
               t_at_abort, after, ab_cnt, done_cnt);
    end
  endtask

  task automatic test_cfg_reject();
    logic [31:0] err_mask;
    int done_at;
    err_mask = '0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      apply(i == 2, 1'b0, i == 0 || i == 1 || i == 4, i == 1 ? 1 : (i == 4 ? 7 : 3),
            i == 4 ? 1 : 2);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL cfg_reject c%0d got=%h want=%h", i, obs(), exp_vec);
      end
      err_mask[i] = cfg_err;
      if (done && done_at < 0) done_at = i;
      advance();
    end
    total++;
    if (err_mask !== 32'h0000_0024 || done_at !== 9) begin
      bad++; $display("FAIL cfg_reject_timing err=%h done_at=%0d want 24 9", err_mask, done_at);
    end
  endtask

  task automatic test_boundary();
    int done_at, max_cnt, max_win, ticks;
    done_at = -1;
    for (int i = 0; i < 6; i++) begin
      apply(i == 1, 1'b0, i == 0, 2, 1);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL bnd_p2 c%0d got=%h want=%h", i, obs(), exp_vec);
      end
      if (done && done_at < 0) done_at = i;
      advance();
    end
    total++;
    if (done_at !== 4) begin
      bad++; $display("FAIL bnd_p2_done got=%0d want=4", done_at);
    end
    done_at = -1; max_cnt = 0; ticks = 0;
    for (int i = 0; i < 2052; i++) begin
      apply(i == 1, 1'b0, i == 0, 1023, 2);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL bnd_p1023 c%0d got=%h want=%h", i, obs(), exp_vec);
      end
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (tick) ticks++;
      if (done && done_at < 0) done_at = i;
      advance();
    end
    total++;
    if (max_cnt !== 1022 || ticks !== 2 || done_at !== 2048) begin
      bad++;
      $display("FAIL bnd_p1023_wrap max=%0d ticks=%0d done_at=%0d want 1022 2 2048",
               max_cnt, ticks, done_at);
    end
    done_at = -1; max_win = 0;
    for (int i = 0; i < 516; i++) begin
      apply(i == 1, 1'b0, i == 0, 2, 255);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL bnd_n255 c%0d got=%h want=%h", i, obs(), exp_vec);
      end
      if (int'(win_idx) > max_win) max_win = int'(win_idx);
      if (done && done_at < 0) done_at = i;
      advance();
    end
    total++;
    if (max_win !== 254 || done_at !== 512) begin
      bad++; $display("FAIL bnd_n255_end max_win=%0d done_at=%0d want 254 512", max_win, done_at);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] marks;
    marks = 'x;
    for (int i = 0; i < 28; i++) begin
      apply(i <= 5 || i == 12 || i == 24, i == 24, i == 0 || i == 12, i == 12 ? 6 : 3, 1);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL simul c%0d got=%h want=%h", i, obs(), exp_vec);
      end
      if (i == 5)  marks[3] = busy;
      if (i == 6)  marks[2] = busy;
      if (i == 18) marks[1] = tick;
      if (i == 25) marks[0] = busy;
      advance();
    end
    total++;
    if (marks !== 4'b0110) begin
      bad++; $display("FAIL simul_events got=%b want=0110", marks);
    end
  endtask

  task automatic test_random();
    bit s, a, we;
    int p, n;
    for (int i = 0; i < 4000; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 40) == 0);
      we = ($urandom_range(0, 19) == 0);
      p  = $urandom_range(0, 9);
      n  = $urandom_range(0, 4);
      apply(s, a, we, p, n);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL random c%0d got=%h want=%h", i, obs(), exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_abort();
    test_cfg_reject();
    test_boundary();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
